// File: rtl/param_reader_2d.sv
// param_reader_2d: read-side sequencer for the 2-D parameter loader.
// Walks every (sel_r, sel_c) address of the loader, captures param_in and
// streams the words to the datapath over a valid/ready handshake.
// Build option: define PARAM_COL_MAJOR_EN for column-major traversal
// (default build is row-major).
module param_reader_2d #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 4,
    parameter int COLS   = 16,
    parameter int R_W    = 2,
    parameter int C_W    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [R_W-1:0]    sel_r,
    output logic [C_W-1:0]    sel_c,
    input  logic [DATA_W-1:0] param_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N + 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t              state_q;
    logic [R_W-1:0]      sel_r_q, sel_r_d;
    logic [C_W-1:0]      sel_c_q, sel_c_d;
    logic [IW-1:0]       issued_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                busy_q;
    logic                done_q;
    logic                load_d;
    logic                hs_d;
    logic                last_addr_d;

    // Load/handshake qualifiers and the next loader address
    always_comb begin
        load_d      = (state_q == STREAM) && (issued_q < IW'(N)) &&
                      (!out_valid_q || out_ready);
        hs_d        = out_valid_q && out_ready;
        last_addr_d = (issued_q == IW'(N - 1));
        sel_r_d     = sel_r_q;
        sel_c_d     = sel_c_q;
`ifdef PARAM_COL_MAJOR_EN
        if (sel_r_q == R_W'(ROWS - 1)) begin
            sel_r_d = '0;
            sel_c_d = (sel_c_q == C_W'(COLS - 1)) ? '0 : sel_c_q + C_W'(1);
        end else begin
            sel_r_d = sel_r_q + R_W'(1);
        end
`else
        if (sel_c_q == C_W'(COLS - 1)) begin
            sel_c_d = '0;
            sel_r_d = (sel_r_q == R_W'(ROWS - 1)) ? '0 : sel_r_q + R_W'(1);
        end else begin
            sel_c_d = sel_c_q + C_W'(1);
        end
`endif
    end

    // Sequencer FSM with registered address, output word and status flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sel_r_q     <= '0;
            sel_c_q     <= '0;
            issued_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= STREAM;
                        sel_r_q  <= '0;
                        sel_c_q  <= '0;
                        issued_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                STREAM: begin
                    if (load_d) begin
                        out_data_q  <= param_in;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_addr_d;
                        sel_r_q     <= sel_r_d;
                        sel_c_q     <= sel_c_d;
                        issued_q    <= issued_q + IW'(1);
                    end else if (hs_d) begin
                        out_valid_q <= 1'b0;
                    end
                    // Final word consumed: the run is over, pulse done next cycle
                    if (hs_d && out_last_q) begin
                        out_last_q <= 1'b0;
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel_r     = sel_r_q;
    assign sel_c     = sel_c_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_param_reader_2d.sv
// Testbench for param_reader_2d: table-driven startup/stall vectors plus
// stream sequences scored against a golden word list built from the
// traversal order.
module tb_param_reader_2d;

    localparam int DATA_W = 16;
    localparam int ROWS   = 4;
    localparam int COLS   = 16;
    localparam int R_W    = 2;
    localparam int C_W    = 4;
    localparam int N      = ROWS * COLS;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [R_W-1:0]    sel_r;
    logic [C_W-1:0]    sel_c;
    logic [DATA_W-1:0] param_in;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    int tests  = 0;
    int failed = 0;

    // Scoreboard state
    bit sb_en = 0;
    int exp_idx = 0;
    int done_cnt = 0;
    logic [15:0] golden [N];

    always #5 clk = ~clk;

    // Loader model: combinational word per address
    assign param_in = 16'hA000 | (16'(sel_r) << 4) | 16'(sel_c);

    param_reader_2d #(
        .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .R_W(R_W), .C_W(C_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .sel_r(sel_r), .sel_c(sel_c), .param_in(param_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    // Traversal order: index i of the stream -> (row, col)
    function automatic int addr_r(input int i);
`ifdef PARAM_COL_MAJOR_EN
        return (i % N) % ROWS;
`else
        return (i % N) / COLS;
`endif
    endfunction

    function automatic int addr_c(input int i);
`ifdef PARAM_COL_MAJOR_EN
        return (i % N) / ROWS;
`else
        return (i % N) % COLS;
`endif
    endfunction

    function automatic logic [15:0] gword(input int i);
        return 16'hA000 | 16'(addr_r(i) << 4) | 16'(addr_c(i));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: capture pre-edge handshake, advance, score accepted word
    task automatic tick();
        logic hs;
        logic [15:0] d;
        logic l;
        hs = (out_valid === 1'b1) && (out_ready === 1'b1);
        d  = out_data;
        l  = out_last;
        @(posedge clk);
        #1;
        if (sb_en && hs) begin
            if (exp_idx < N) begin
                chk("word", 32'(d), 32'(golden[exp_idx]));
                chk("last", 32'(l), 32'(exp_idx == N - 1));
            end else begin
                chk("extra_word", 32'(exp_idx), 32'(N - 1));
            end
            exp_idx++;
        end
        if (sb_en && done === 1'b1) begin
            done_cnt++;
            chk("done_vs_valid", 32'(out_valid), 32'd0);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        st;
        logic        rdy;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_busy;
        logic        exp_done;
        int          exp_r;
        int          exp_c;
    } vec_t;

    vec_t vt [8];

    // Stream one full run. mode 0: ready=1, 1: random ready,
    // 2: 3-cycle stall on word 5, 3: extra start at word 10.
    task automatic run(input int mode);
        int dt;
        int gaps;
        bit stalled;
        bit restarted;
        dt = -1; gaps = 0; stalled = 0; restarted = 0;
        exp_idx = 0; done_cnt = 0; sb_en = 1;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 600 && dt < 0; i++) begin
            if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b1;
            if (mode == 2 && !stalled && out_valid && out_data == golden[5]) begin
                stalled = 1;
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("bp_valid", 32'(out_valid), 32'd1);
                    chk("bp_data", 32'(out_data), 32'(golden[5]));
                    chk("bp_sel_r", 32'(sel_r), 32'(addr_r(6)));
                    chk("bp_sel_c", 32'(sel_c), 32'(addr_c(6)));
                    chk("bp_last", 32'(out_last), 32'd0);
                end
                out_ready = 1'b1;
            end
            if (mode == 3 && !restarted && exp_idx == 10) begin
                restarted = 1;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (mode == 0 && i <= N && out_valid !== 1'b1) gaps++;
            if (mode == 0 && i == 1) chk("first_word", 32'(out_data), 32'(golden[0]));
            if (done === 1'b1) dt = i;
        end
        chk("done_seen", 32'(dt >= 0), 32'd1);
        chk("word_count", 32'(exp_idx), 32'(N));
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        if (mode == 2) chk("stall_hit", 32'(stalled), 32'd1);
        if (mode == 0) begin
            chk("done_latency", 32'(dt), 32'(N + 1));
            chk("no_gaps", 32'(gaps), 32'd0);
        end
    endtask

    task automatic do_reset();
        sb_en = 0;
        reset_n = 1'b0;
        start = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) golden[i] = gword(i);

        // rst_n, start, ready, valid, data, busy, done, sel_r, sel_c (after edge)
        vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000,  1'b0, 1'b0, 0, 0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000,  1'b1, 1'b0, 0, 0};
        vt[2] = '{1'b1, 1'b0, 1'b1, 1'b1, golden[0], 1'b1, 1'b0, addr_r(1), addr_c(1)};
        vt[3] = '{1'b1, 1'b0, 1'b0, 1'b1, golden[0], 1'b1, 1'b0, addr_r(1), addr_c(1)};
        vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, golden[0], 1'b1, 1'b0, addr_r(1), addr_c(1)};
        vt[5] = '{1'b1, 1'b0, 1'b1, 1'b1, golden[1], 1'b1, 1'b0, addr_r(2), addr_c(2)};
        vt[6] = '{1'b1, 1'b1, 1'b1, 1'b1, golden[2], 1'b1, 1'b0, addr_r(3), addr_c(3)};
        vt[7] = '{1'b1, 1'b0, 1'b1, 1'b1, golden[3], 1'b1, 1'b0, addr_r(4), addr_c(4)};

        reset_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            reset_n   = vt[i].rst_n;
            start     = vt[i].st;
            out_ready = vt[i].rdy;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].exp_valid));
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vt[i].exp_data));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].exp_done));
            chk($sformatf("vec%0d_sel_r", i), 32'(sel_r), 32'(vt[i].exp_r));
            chk($sformatf("vec%0d_sel_c", i), 32'(sel_c), 32'(vt[i].exp_c));
            chk($sformatf("vec%0d_last", i), 32'(out_last), 32'd0);
        end
        start = 1'b0;
        do_reset();

        // Full stream, no backpressure
        run(0);
        tick(); tick();
        chk("done_one_cycle", 32'(done_cnt), 32'd1);

        // Backpressure on word 5
        run(2);

        // Start ignored mid-run, then start accepted in the done cycle
        run(3);
        chk("done_cycle_is_now", 32'(done), 32'd1);
        sb_en = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);
        tick();
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_word", 32'(out_data), 32'(golden[0]));

        // Reset mid-stream at word 20
        do_reset();
        exp_idx = 0; done_cnt = 0; sb_en = 1;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && exp_idx < 20; i++) tick();
        chk("reached_word20", 32'(exp_idx), 32'd20);
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel_r", 32'(sel_r), 32'd0);
        chk("rst_sel_c", 32'(sel_c), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        done_cnt = 0; sb_en = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        chk("rst_idle_valid", 32'(out_valid), 32'd0);
        run(0);

        // Randomized backpressure
        for (int r = 0; r < 3; r++) run(1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
